// File: rtl/wdt32_seq_pkg.sv
// wdt32_seq_pkg -- shared types and constants for the WDT32 sequencer.
// Contents: FSM state enum, unlock/service key values and register word offsets
// (these offsets are decoded from PADDR[4:2]).
package wdt32_seq_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WARN     = 2'd2,
    ST_RESET    = 2'd3
  } wdt_state_e;

  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;
  localparam logic [31:0] SVC_KEY1   = 32'h0000_5555;
  localparam logic [31:0] SVC_KEY2   = 32'h0000_AAAA;

  localparam logic [2:0] OFF_CTRL    = 3'd0;  // 0x00
  localparam logic [2:0] OFF_LOAD    = 3'd1;  // 0x04
  localparam logic [2:0] OFF_SERVICE = 3'd2;  // 0x08
  localparam logic [2:0] OFF_LOCK    = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_STATUS  = 3'd4;  // 0x10
  localparam logic [2:0] OFF_COUNT   = 3'd5;  // 0x14
  localparam logic [2:0] OFF_WIN     = 3'd6;  // 0x18, window build only

  // True for a completed APB write (access phase) to the given offset.
  function automatic logic wr_hit(input logic wr, input logic [2:0] off,
                                  input logic [2:0] target);
    return wr && (off == target);
  endfunction

endpackage

// File: rtl/wdt32_seq_if.sv
// wdt32_seq_if -- APB3 slave bus bundle for the WDT32 sequencer.
// Signals: PSEL, PENABLE, PWRITE, PADDR[19:2], PWDATA[31:0] (master -> slave),
//          PRDATA[31:0], PREADY (slave -> master).
// Modports: master (bus driver), slave (wdt32_seq).
interface wdt32_seq_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [19:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY);
endinterface

// File: rtl/wdt32_key_det.sv
// wdt32_key_det -- two-write service sequence detector.
// A SERVICE write of 5555 arms a pending flag; the next APB write completes the
// service only if it is SERVICE=AAAA. Any other write drops the pending flag.
// Ports: PCLK, PRESETn (async, active-low), wr_en (APB access-phase write),
//        svc_sel (write targets SERVICE), wdata (PWDATA),
//        svc_stb (service strobe, high during the completing access phase).
module wdt32_key_det
  import wdt32_seq_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        wr_en,
  input  logic        svc_sel,
  input  logic [31:0] wdata,
  output logic        svc_stb
);

  logic pend_q;

  // APB access phase lasts exactly one cycle (PREADY tied high), so the
  // combinational strobe is a single-cycle pulse.
  assign svc_stb = wr_en & svc_sel & (wdata == SVC_KEY2) & pend_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)   pend_q <= 1'b0;
    else if (wr_en) pend_q <= svc_sel & (wdata == SVC_KEY1);
  end

endmodule

// File: rtl/wdt32_seq.sv
// wdt32_seq -- APB-programmed sequencer wrapped around a WDT32 counter.
// Ports: PCLK, PRESETn (async, active-low); apb (wdt32_seq_if.slave);
//        WDTMR/WDOV from the counter; WDLOAD/WDEN/WDOVCLR to the counter;
//        IRQ warning interrupt; SYSRST_REQ system reset request.
// Params: RST_PULSE_W (1..255) SYSRST_REQ width, ERR_DATA unmapped read value.
// Build option: define WDT32_SEQ_WINDOW_EN to add the WIN register at 0x18;
//   a service while WDTMR > WIN then counts as an overflow event.
module wdt32_seq
  import wdt32_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_W = 16,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  wdt32_seq_if.slave  apb,
  input  logic [31:0] WDTMR,
  input  logic        WDOV,
  output logic [31:0] WDLOAD,
  output logic        WDEN,
  output logic        WDOVCLR,
  output logic        IRQ,
  output logic        SYSRST_REQ
);

  localparam logic [1:0] S_DISABLED = ST_DISABLED;
  localparam logic [1:0] S_ARMED    = ST_ARMED;
  localparam logic [1:0] S_WARN     = ST_WARN;
  localparam logic [1:0] S_RESET    = ST_RESET;
  localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE_W - 1);

  logic [2:0]  ctrl_q;      // {IRQEN, RSTEN, EN}
  logic [31:0] load_q;
  logic        locked_q;
  logic        irqf_q;
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wdov_q;
  logic        clr_q;

  logic [2:0]  off;
  logic        wr;
  logic        ctrl_acc, load_acc, relock;
  logic        svc, svc_ok, early, ov_evt;
  logic        clr_req, irq_set, en_clr;
  logic        unused_ok;

  assign off       = apb.PADDR[4:2];
  assign wr        = apb.PSEL & apb.PWRITE & apb.PENABLE;
  assign unused_ok = ^apb.PADDR[19:5];
  assign apb.PREADY = 1'b1;

  // CTRL is frozen while locked and for the whole reset pulse.
  assign ctrl_acc = wr_hit(wr, off, OFF_CTRL) & ~locked_q & (state_q != S_RESET);
  assign load_acc = wr_hit(wr, off, OFF_LOAD) & ~locked_q;

  wdt32_key_det u_key_det (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_en   (wr),
    .svc_sel (off == OFF_SERVICE),
    .wdata   (apb.PWDATA),
    .svc_stb (svc)
  );

`ifdef WDT32_SEQ_WINDOW_EN
  logic [31:0] win_q;
  logic        win_acc;

  assign win_acc = wr_hit(wr, off, OFF_WIN) & ~locked_q;
  assign early   = svc & (WDTMR > win_q);
  assign relock  = wr_hit(wr, off, OFF_CTRL) | wr_hit(wr, off, OFF_LOAD) |
                   wr_hit(wr, off, OFF_WIN);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)     win_q <= '0;
    else if (win_acc) win_q <= apb.PWDATA;
  end
`else
  assign early  = 1'b0;
  assign relock = wr_hit(wr, off, OFF_CTRL) | wr_hit(wr, off, OFF_LOAD);
`endif

  // An early (in-window) service is treated exactly like a counter overflow.
  assign svc_ok = svc & ~early;
  assign ov_evt = (WDOV & ~wdov_q) | early;

  // Next-state logic. Priority inside ARMED/WARN: disable write, then a good
  // service (so a service coinciding with an overflow wins), then overflow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_req = 1'b0;
    irq_set = 1'b0;
    en_clr  = 1'b0;
    case (state_q)
      S_DISABLED: begin
        if (ctrl_acc && apb.PWDATA[0]) begin
          state_d = S_ARMED;
          clr_req = 1'b1;
        end
      end
      S_ARMED: begin
        if (ctrl_acc && !apb.PWDATA[0]) begin
          state_d = S_DISABLED;
        end else if (svc_ok) begin
          clr_req = 1'b1;
        end else if (ov_evt) begin
          state_d = S_WARN;
          irq_set = 1'b1;
          clr_req = 1'b1;
        end
      end
      S_WARN: begin
        if (ctrl_acc && !apb.PWDATA[0]) begin
          state_d = S_DISABLED;
        end else if (svc_ok) begin
          state_d = S_ARMED;
          clr_req = 1'b1;
        end else if (ov_evt) begin
          if (ctrl_q[1]) begin
            state_d = S_RESET;
            cnt_d   = '0;
          end else begin
            clr_req = 1'b1;
          end
        end
      end
      S_RESET: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_DISABLED;
          cnt_d   = '0;
          en_clr  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_DISABLED;
      cnt_q   <= '0;
      wdov_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdov_q  <= WDOV;
      // Back-to-back requests collapse so the counter never sees a 2-cycle clear.
      clr_q   <= clr_req & ~clr_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q   <= '0;
      load_q   <= '0;
      locked_q <= 1'b1;
      irqf_q   <= 1'b0;
    end else begin
      if (ctrl_acc)    ctrl_q    <= apb.PWDATA[2:0];
      else if (en_clr) ctrl_q[0] <= 1'b0;

      if (load_acc) load_q <= apb.PWDATA;

      // Any LOCK write other than the key locks; a lock-protected register
      // write (accepted or not) also re-locks.
      if (wr_hit(wr, off, OFF_LOCK)) locked_q <= (apb.PWDATA != UNLOCK_KEY);
      else if (relock)               locked_q <= 1'b1;

      // Set has priority over the write-1-to-clear.
      if (irq_set)                                        irqf_q <= 1'b1;
      else if (wr_hit(wr, off, OFF_STATUS) && apb.PWDATA[3]) irqf_q <= 1'b0;
    end
  end

  // Read mux: purely combinational from PADDR, no read side effects.
  always_comb begin
    apb.PRDATA = ERR_DATA;
    case (off)
      OFF_CTRL:    apb.PRDATA = {29'd0, ctrl_q};
      OFF_LOAD:    apb.PRDATA = load_q;
      OFF_SERVICE: apb.PRDATA = '0;
      OFF_LOCK:    apb.PRDATA = {31'd0, locked_q};
      OFF_STATUS:  apb.PRDATA = {28'd0, irqf_q, WDOV, state_q};
      OFF_COUNT:   apb.PRDATA = WDTMR;
`ifdef WDT32_SEQ_WINDOW_EN
      OFF_WIN:     apb.PRDATA = win_q;
`endif
      default:     apb.PRDATA = ERR_DATA;
    endcase
  end

  assign WDLOAD     = load_q;
  assign WDEN       = (state_q == S_ARMED) | (state_q == S_WARN);
  assign WDOVCLR    = clr_q;
  assign IRQ        = irqf_q & ctrl_q[2];
  assign SYSRST_REQ = (state_q == S_RESET);

endmodule
